frame_ram_arbiter: RTL and testbench
====================================

# frame_ram_arbiter

Single-port access arbiter and bank scheduler for `frame_ram`.
- Shares the one RAM port between the display read path (`led_display_ram_control`) and a host pixel-write port.
- Display reads have priority; writes are guaranteed bounded latency.
- Optional double buffering: the display reads a front bank while the host fills a back bank, with swaps executed only at frame boundaries.

## Interface
Parameters:
- `ADDR_WIDTH`, 13, RAM address width; requester addresses are `ADDR_WIDTH-1` bits wide (LADDR), MSB is the bank bit.
- `DATA_WIDTH`, 64, RAM word width.
- `RD_LATENCY`, 2, RAM read latency in cycles, ≥1.
- `MAX_WR_STALL`, 8, max consecutive cycles a pending write is denied by reads, ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk_in` in 1: system clock.
- `reset_in` in 1: async active-high reset.
- `rd_req_in` in 1: reader requests a read; held with address until acked.
- `rd_addr_in` in LADDR: read address.
- `rd_ack_out` out 1: read granted this cycle.
- `rd_data_out` out DATA_WIDTH: passthrough of `ram_dout_in`.
- `rd_data_valid_out` out 1: `rd_data_out` valid.
- `frame_start_in` in 1: one-cycle pulse from the reader at the start of each frame, ≥1 cycle before the first row-0 read.
- `wr_valid_in` in 1: host write valid.
- `wr_addr_in` in LADDR: write address.
- `wr_data_in` in DATA_WIDTH: write data.
- `wr_ready_out` out 1: write accepted when high together with `wr_valid_in`.
- `swap_req_in` in 1: host pulse requesting a bank swap.
- `swap_done_out` out 1: one-cycle pulse when the swap has completed.
- `front_bank_out` out 1: current display bank.
- `ram_we_out` out 1: drives `frame_ram` `wea`.
- `ram_addr_out` out ADDR_WIDTH: drives `frame_ram` `addra`.
- `ram_din_out` out DATA_WIDTH: drives `frame_ram` `dina`.
- `ram_dout_in` in DATA_WIDTH: driven by `frame_ram` `douta`.

## Operation
- At most one RAM operation per cycle. The grant is combinational from the current requests and registered state.
- Grant rule, in order:
  - Write wins if `wr_valid_in` && not blocked && `stall_cnt == MAX_WR_STALL`.
  - Otherwise, read wins if `rd_req_in`.
  - Otherwise, write wins if `wr_valid_in` && not blocked.
- A write is "blocked" only while the swap is pending (double-buffer build).
- `stall_cnt`:
  - Increments, saturating at `MAX_WR_STALL`, on each cycle with `wr_valid_in` && !blocked && write not granted.
  - Clears on a write grant, or when `wr_valid_in` is low.
- Read grant: `rd_ack_out=1`, `ram_we_out=0`, `ram_addr_out={rd_bank, rd_addr_in}`.
- Write grant: `wr_ready_out=1`, `ram_we_out=1`, `ram_addr_out={wr_bank, wr_addr_in}`, `ram_din_out=wr_data_in`.
- Idle cycle: `ram_we_out=0`; `ram_addr_out` and `ram_din_out` are 0.
- `wr_ready_out` may depend combinationally on `wr_valid_in`. `rd_ack_out` may depend combinationally on `rd_req_in`.
- Read-valid tracking: a `RD_LATENCY`-deep shift register of read grants drives `rd_data_valid_out`.
- Swap FSM states: IDLE, PENDING.
  - IDLE → PENDING on `swap_req_in`.
  - PENDING → IDLE on `frame_start_in`: `front_bank` toggles at that edge, and `swap_done_out` pulses the next cycle.
  - `swap_req_in` while PENDING is ignored.
  - `swap_req_in` and `frame_start_in` in the same IDLE cycle: enter PENDING; the swap waits for the next frame start.
- Bank mapping: `rd_bank = front_bank`, `wr_bank = ~front_bank`.
  - A read granted in the `frame_start_in` cycle uses the old bank.
  - Reads already in flight complete unaffected.
- Reset, asserted at any time:
  - Outputs: all outputs 0; `front_bank=0`; FSM IDLE; `stall_cnt=0`; valid pipeline cleared.
  - In-flight reads: they never produce `rd_data_valid_out`.

## Timing
- Read: ack in cycle N; `rd_data_valid_out` high in cycle N+`RD_LATENCY`; one valid per ack; back-to-back acks give back-to-back valids.
- Write: committed at the edge ending the handshake cycle. A read of the same address granted the next cycle returns the new data.
- Worst-case write wait with continuous reads: `MAX_WR_STALL`+1 cycles from `wr_valid_in` (no swap pending).
- Swap latency: from the first `frame_start_in` after the request to `swap_done_out`: 1 cycle.

## Configuration
- Macro: `FRAME_RAM_DOUBLE_BUFFER_EN`.
- Defined: swap FSM and bank logic as above.
- Undefined:
  - Bank bit and outputs: `ram_addr_out` MSB is always 0, `front_bank_out` is tied 0, and writes are never blocked.
  - Swap handshake: `swap_done_out` pulses one cycle after `swap_req_in`, so host code is build-independent. `frame_start_in` is ignored.

## Structure
- `led_display_package` gains:
  - `FRAME_ADDR_WIDTH=13`, `FRAME_DATA_WIDTH=64`, `FRAME_RD_LATENCY=2` constants.
  - `typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t`.
- One sub-module, `frame_bank_ctrl`: swap FSM, `front_bank` register, `swap_done_out` generation, macro-dependent behaviour.
- The arbiter, stall counter and valid pipeline live in `frame_ram_arbiter`.

## Test plan
- Reset mid-read: ack read at address 0x010, assert `reset_in` the next cycle → all outputs 0, no `rd_data_valid_out`, `front_bank_out=0`.
- Write then read: write 0x0123_4567_89AB_CDEF to LADDR 0x005 (bank 1 when double-buffered), read LADDR 0x005 after a swap → data matches, valid exactly 2 cycles after ack.
- Starvation guard: `rd_req_in` held high continuously with `wr_valid_in` high → write granted on the 9th cycle of `wr_valid_in`, `rd_ack_out` low that cycle, reads resume the next cycle.
- Simultaneous requests with `stall_cnt=0`: read acked, `wr_ready_out=0`, `stall_cnt=1`.
- Swap: `swap_req_in` pulse, 20 cycles of writes attempted → `wr_ready_out` stays 0 until `frame_start_in`; `front_bank_out` flips at that edge; `swap_done_out` pulses once a cycle later.
- Macro off: `swap_req_in` → `swap_done_out` one cycle later, `ram_addr_out[12]` always 0, writes never blocked.

Source files
------------

// File: rtl/led_display_package.sv
// Shared constants and types for the LED display frame buffer path.
package led_display_package;

  localparam int FRAME_ADDR_WIDTH = 13;
  localparam int FRAME_DATA_WIDTH = 64;
  localparam int FRAME_RD_LATENCY = 2;

  typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t;

endpackage

// File: rtl/frame_ram_arbiter_if.sv
// Requester, swap and RAM-side signals of frame_ram_arbiter, bundled with
// slave (arbiter) and master (host/reader/RAM side) modports.
interface frame_ram_arbiter_if
  import led_display_package::*;
#(
  parameter int ADDR_WIDTH = FRAME_ADDR_WIDTH,
  parameter int DATA_WIDTH = FRAME_DATA_WIDTH
);

  logic                  rd_req_in;
  logic [ADDR_WIDTH-2:0] rd_addr_in;
  logic                  rd_ack_out;
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  rd_data_valid_out;
  logic                  frame_start_in;

  logic                  wr_valid_in;
  logic [ADDR_WIDTH-2:0] wr_addr_in;
  logic [DATA_WIDTH-1:0] wr_data_in;
  logic                  wr_ready_out;

  logic                  swap_req_in;
  logic                  swap_done_out;
  logic                  front_bank_out;

  logic                  ram_we_out;
  logic [ADDR_WIDTH-1:0] ram_addr_out;
  logic [DATA_WIDTH-1:0] ram_din_out;
  logic [DATA_WIDTH-1:0] ram_dout_in;

  modport slave (
    input  rd_req_in, rd_addr_in, frame_start_in,
    input  wr_valid_in, wr_addr_in, wr_data_in,
    input  swap_req_in, ram_dout_in,
    output rd_ack_out, rd_data_out, rd_data_valid_out, wr_ready_out,
    output swap_done_out, front_bank_out,
    output ram_we_out, ram_addr_out, ram_din_out
  );

  modport master (
    output rd_req_in, rd_addr_in, frame_start_in,
    output wr_valid_in, wr_addr_in, wr_data_in,
    output swap_req_in, ram_dout_in,
    input  rd_ack_out, rd_data_out, rd_data_valid_out, wr_ready_out,
    input  swap_done_out, front_bank_out,
    input  ram_we_out, ram_addr_out, ram_din_out
  );

endinterface

// File: rtl/frame_bank_ctrl.sv
// Bank swap controller: front-bank register, swap FSM and swap_done pulse.
// Double buffering is enabled by defining FRAME_RAM_DOUBLE_BUFFER_EN.
module frame_bank_ctrl
  import led_display_package::*;
(
  input  logic clk,
  input  logic rst,
  input  logic swap_req,
  input  logic frame_start,
  output logic front_bank,
  output logic rd_bank,
  output logic wr_bank,
  output logic blocked,
  output logic swap_done
);

`ifdef FRAME_RAM_DOUBLE_BUFFER_EN

  swap_state_t state_q, state_d;
  logic        front_q, front_d;
  logic        done_q, done_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SWAP_IDLE;
      front_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    done_d  = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        // A frame_start in the same cycle as the request does not complete it.
        if (swap_req) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (frame_start) begin
          state_d = SWAP_IDLE;
          front_d = ~front_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  assign front_bank = front_q;
  assign rd_bank    = front_q;
  assign wr_bank    = ~front_q;
  assign blocked    = (state_q == SWAP_PENDING);
  assign swap_done  = done_q;

`else

  // Single-buffer build: acknowledge swaps after one cycle so host code is
  // identical in both builds; the bank bit stays 0.
  logic done_q;
  logic unused_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= swap_req;
  end

  assign unused_frame_start = frame_start;
  assign front_bank = 1'b0;
  assign rd_bank    = 1'b0;
  assign wr_bank    = 1'b0;
  assign blocked    = 1'b0;
  assign swap_done  = done_q;

`endif

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame_ram arbiter: display reads have priority, host writes get
// bounded latency via a stall counter; banking lives in frame_bank_ctrl.
module frame_ram_arbiter
  import led_display_package::*;
#(
  parameter int ADDR_WIDTH   = FRAME_ADDR_WIDTH,
  parameter int DATA_WIDTH   = FRAME_DATA_WIDTH,
  parameter int RD_LATENCY   = FRAME_RD_LATENCY,
  parameter int MAX_WR_STALL = 8
) (
  input  logic                clk_in,
  input  logic                reset_in,
  frame_ram_arbiter_if.slave  bus
);

  localparam int                 STALL_W   = $clog2(MAX_WR_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_WR_STALL);

  logic                  front_bank, rd_bank, wr_bank, blocked, swap_done;
  logic                  wr_eligible, rd_grant, wr_grant;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [RD_LATENCY-1:0] vld_q;

  frame_bank_ctrl u_bank (
    .clk         (clk_in),
    .rst         (reset_in),
    .swap_req    (bus.swap_req_in),
    .frame_start (bus.frame_start_in),
    .front_bank  (front_bank),
    .rd_bank     (rd_bank),
    .wr_bank     (wr_bank),
    .blocked     (blocked),
    .swap_done   (swap_done)
  );

  // Grants are suppressed while reset is asserted so all outputs read 0.
  always_comb begin
    wr_eligible = bus.wr_valid_in && !blocked;
    rd_grant    = 1'b0;
    wr_grant    = 1'b0;
    if (!reset_in) begin
      if (wr_eligible && stall_q == STALL_MAX) wr_grant = 1'b1;
      else if (bus.rd_req_in)                  rd_grant = 1'b1;
      else if (wr_eligible)                    wr_grant = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!bus.wr_valid_in || wr_grant)         stall_d = '0;
    else if (!blocked && stall_q != STALL_MAX) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      stall_q <= '0;
      vld_q   <= '0;
    end else begin
      stall_q  <= stall_d;
      vld_q[0] <= rd_grant;
      for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign bus.rd_ack_out        = rd_grant;
  assign bus.wr_ready_out      = wr_grant;
  assign bus.ram_we_out        = wr_grant;
  assign bus.ram_addr_out      = rd_grant ? {rd_bank, bus.rd_addr_in} :
                                 wr_grant ? {wr_bank, bus.wr_addr_in} :
                                 {ADDR_WIDTH{1'b0}};
  assign bus.ram_din_out       = wr_grant ? bus.wr_data_in : {DATA_WIDTH{1'b0}};
  assign bus.rd_data_out       = reset_in ? {DATA_WIDTH{1'b0}} : bus.ram_dout_in;
  assign bus.rd_data_valid_out = vld_q[RD_LATENCY-1];
  assign bus.swap_done_out     = swap_done;
  assign bus.front_bank_out    = front_bank;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench for frame_ram_arbiter: directed vectors, corner-case
// sequences and randomized traffic against a cycle-level reference model.
module tb_frame_ram_arbiter;
  import led_display_package::*;

  localparam int AW   = 13;
  localparam int DW   = 64;
  localparam int RDL  = 2;
  localparam int MAXS = 8;
  localparam int LA   = AW - 1;
`ifdef FRAME_RAM_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  frame_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  frame_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .MAX_WR_STALL(MAXS)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  // Behavioural frame_ram: 2-cycle read latency, write commits at the edge.
  logic          ram_init;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe, dout_q;
  always @(posedge clk_in) begin
    if (ram_init) for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    else if (bus.ram_we_out) mem[bus.ram_addr_out] <= bus.ram_din_out;
    rd_pipe <= mem[bus.ram_addr_out];
    dout_q  <= rd_pipe;
  end
  assign bus.ram_dout_in = dout_q;

  typedef struct {
    logic          ack, ready, we, valid, done, front;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, data;
  } outs_t;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model state, expressed as waiting time, pending flag and a
  // list of read issue cycles with the data each read must return.
  int            m_wait;
  bit            m_pending, m_front, m_done_next;
  int            cyc;
  int            ack_cyc[$];
  logic [DW-1:0] ack_data[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  task automatic model_reset();
    m_wait = 0; m_pending = 0; m_front = 0; m_done_next = 0;
    ack_cyc.delete(); ack_data.delete();
  endtask

  task automatic drive(input bit rd, input logic [LA-1:0] ra, input bit wv,
                       input logic [LA-1:0] wa, input logic [DW-1:0] wd,
                       input bit sw, input bit fs);
    bus.rd_req_in = rd; bus.rd_addr_in = ra;
    bus.wr_valid_in = wv; bus.wr_addr_in = wa; bus.wr_data_in = wd;
    bus.swap_req_in = sw; bus.frame_start_in = fs;
  endtask

  task automatic sample(output outs_t o);
    o.ack = bus.rd_ack_out;   o.ready = bus.wr_ready_out; o.we = bus.ram_we_out;
    o.valid = bus.rd_data_valid_out; o.done = bus.swap_done_out;
    o.front = bus.front_bank_out; o.addr = bus.ram_addr_out;
    o.din = bus.ram_din_out;  o.data = bus.rd_data_out;
  endtask

  // One clock cycle: drive, sample at negedge, compare with model, advance.
  task automatic step(input bit rd, input logic [LA-1:0] ra, input bit wv,
                      input logic [LA-1:0] wa, input logic [DW-1:0] wd,
                      input bit sw, input bit fs, output outs_t o);
    bit blocked, wcan, force_wr, e_rd, e_wr, e_valid, rb, wb;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    drive(rd, ra, wv, wa, wd, sw, fs);
    @(negedge clk_in);
    sample(o);
    blocked  = DB && m_pending;
    wcan     = wv && !blocked;
    force_wr = wcan && (m_wait >= MAXS);
    e_wr     = force_wr || (wcan && !rd);
    e_rd     = rd && !force_wr;
    rb       = DB ? m_front : 1'b0;
    wb       = DB ? ~m_front : 1'b0;
    e_addr   = e_rd ? {rb, ra} : (e_wr ? {wb, wa} : '0);
    e_din    = e_wr ? wd : '0;
    e_valid  = (ack_cyc.size() != 0) && (ack_cyc[0] + RDL == cyc);
    check("rd_ack", o.ack, e_rd);
    check("wr_ready", o.ready, e_wr);
    check("ram_we", o.we, e_wr);
    check("ram_addr", o.addr, e_addr);
    check("ram_din", o.din, e_din);
    check("rd_valid", o.valid, e_valid);
    check("swap_done", o.done, m_done_next);
    check("front_bank", o.front, DB ? m_front : 1'b0);
    if (e_valid) begin
      check("rd_data", o.data, ack_data[0]);
      void'(ack_cyc.pop_front());
      void'(ack_data.pop_front());
    end
    if (e_rd) begin
      ack_cyc.push_back(cyc);
      ack_data.push_back(shadow[{rb, ra}]);
    end
    if (e_wr) shadow[{wb, wa}] = wd;
    m_wait = (!wv || e_wr) ? 0 : (blocked ? m_wait : m_wait + 1);
    if (DB) begin
      m_done_next = m_pending && fs;
      if (m_pending && fs) begin m_front = ~m_front; m_pending = 0; end
      else if (!m_pending && sw) m_pending = 1;
    end else begin
      m_done_next = sw;
    end
    @(posedge clk_in); #1;
    cyc++;
  endtask

  task automatic idle(output outs_t o);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, o);
  endtask

  // Hold reset for n cycles with whatever inputs are driven; all outputs 0.
  task automatic reset_for(input int n);
    outs_t o;
    reset_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      sample(o);
      check("rst_ack", o.ack, 0);     check("rst_ready", o.ready, 0);
      check("rst_we", o.we, 0);       check("rst_addr", o.addr, 0);
      check("rst_din", o.din, 0);     check("rst_valid", o.valid, 0);
      check("rst_data", o.data, 0);   check("rst_done", o.done, 0);
      check("rst_front", o.front, 0);
      @(posedge clk_in); #1;
      cyc++;
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    reset_in = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit            rd;
    logic [LA-1:0] ra;
    bit            wv;
    logic [LA-1:0] wa;
    logic [DW-1:0] wd;
    bit            e_ack, e_rdy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
  } vec_t;

  localparam logic [DW-1:0] PIX = 64'h0123_4567_89AB_CDEF;

  initial begin
    vec_t  vecs[6];
    outs_t o;
    logic  wbit;
    wbit = DB;  // front bank is 0 after reset, so writes go to bank DB

    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    cyc = 0;
    model_reset();
    ram_init = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk_in); #1;
    reset_for(2);
    ram_init = 1'b0;

    vecs[0] = '{0, 12'h000, 0, 12'h000, 64'h0,        0, 0, 13'h0000,             64'h0};
    vecs[1] = '{1, 12'h010, 0, 12'h000, 64'h0,        1, 0, {1'b0, 12'h010},      64'h0};
    vecs[2] = '{0, 12'h000, 1, 12'h005, PIX,          0, 1, {wbit, 12'h005},      PIX};
    vecs[3] = '{1, 12'h7FF, 1, 12'h123, 64'h55,       1, 0, {1'b0, 12'h7FF},      64'h0};
    vecs[4] = '{0, 12'h000, 1, 12'hFFF, {64{1'b1}},   0, 1, {wbit, 12'hFFF},      {64{1'b1}}};
    vecs[5] = '{1, 12'h000, 0, 12'h000, 64'h0,        1, 0, 13'h0000,             64'h0};
    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd, 1'b0, 1'b0, o);
      check("vec_ack", o.ack, vecs[i].e_ack);
      check("vec_ready", o.ready, vecs[i].e_rdy);
      check("vec_addr", o.addr, vecs[i].e_addr);
      check("vec_din", o.din, vecs[i].e_din);
      idle(o);
      idle(o);
    end

    // Continuous reads: the write wins on its 9th waiting cycle only.
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 12'h020, i <= 9, 12'h0AA, 64'hBEEF_0000 + 64'(i), 1'b0, 1'b0, o);
      check("starve_ready", o.ready, i == 9);
      check("starve_ack", o.ack, i != 9);
    end
    idle(o); idle(o); idle(o);

    // Write to the back bank, swap at a frame start, read it back.
    step(1'b0, '0, 1'b1, 12'h005, PIX, 1'b0, 1'b0, o);
    check("wr_pix_ready", o.ready, 1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, o);
    check("swap_req_done", o.done, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b1, 12'h100 + 12'(i), 64'(i), 1'b0, 1'b0, o);
      check("swap_wr_ready", o.ready, !DB);
      check("swap_done_early", o.done, !DB && i == 0);
      check("swap_front_old", o.front, 0);
    end
    step(1'b0, '0, 1'b1, 12'h200, 64'h77, 1'b0, 1'b1, o);
    check("fs_wr_ready", o.ready, !DB);
    check("fs_front_old", o.front, 0);
    idle(o);
    check("swap_front_new", o.front, DB);
    check("swap_done_pulse", o.done, DB);
    idle(o);
    check("swap_done_single", o.done, 0);
    step(1'b1, 12'h005, 1'b0, '0, '0, 1'b0, 1'b0, o);
    check("rb_ack", o.ack, 1);
    check("rb_addr", o.addr, {DB, 12'h005});
    idle(o);
    check("rb_valid_n1", o.valid, 0);
    idle(o);
    check("rb_valid_n2", o.valid, 1);
    check("rb_data", o.data, PIX);
    idle(o);
    check("rb_valid_n3", o.valid, 0);

    // Reset one cycle after a read ack: the read never completes.
    step(1'b1, 12'h010, 1'b0, '0, '0, 1'b0, 1'b0, o);
    check("mid_ack", o.ack, 1);
    drive(1'b1, 12'h010, 1'b1, 12'h011, 64'h99, 1'b1, 1'b1);
    reset_for(3);
    for (int i = 0; i < 3; i++) begin
      idle(o);
      check("post_rst_valid", o.valid, 0);
      check("post_rst_front", o.front, 0);
    end

    // Randomized traffic on a small address window to force reuse.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(9) < 7, LA'($urandom_range(15)), 1'($urandom_range(1)),
           LA'($urandom_range(15)), {$urandom, $urandom},
           $urandom_range(31) == 0, $urandom_range(15) == 0, o);
    end
    idle(o); idle(o); idle(o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
